// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - payload/valid/stall/flush bundle for one pipeline stage register
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 9
);
  logic [WIDTH-1:0] i_d;
  logic             i_valid_in;
  logic             i_stall;
  logic             i_flush;
  logic [WIDTH-1:0] o_q;
  logic             o_valid_out;

  // Upstream pipeline logic drives payload and control, observes the registered stage.
  modport master (
    output i_d, i_valid_in, i_stall, i_flush,
    input  o_q, o_valid_out
  );

  // The stage register itself.
  modport slave (
    input  i_d, i_valid_in, i_stall, i_flush,
    output o_q, o_valid_out
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with stall, flush, debug halt/step and stall counter
module pipe_stage_reg #(
  parameter int unsigned      WIDTH       = 9,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter bit               RESET_VALID = 1'b1,
  parameter logic [WIDTH-1:0] BUBBLE_VAL  = '0,
  parameter int unsigned      CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable_debug,
  input  logic             i_step,
  input  logic             i_clr_cnt,
  pipe_stage_reg_if.slave  bus,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic             r_halted;
  logic             r_step_seen;
  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_live;

  // The stage advances in RUN (unless debug is being raised this very cycle) and for the one STEP cycle.
  assign w_live = ((r_state == ST_RUN) && !i_enable_debug) || (r_state == ST_STEP);

  // Debug FSM; halted is registered alongside the state so it mirrors HALT exactly.
  // step_seen makes a held step produce one advance; it re-arms on a HALT cycle with step low.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_RUN;
      r_halted    <= 1'b0;
      r_step_seen <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_enable_debug) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end
        end
        ST_HALT: begin
          if (!i_enable_debug) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end else if (i_step && !r_step_seen) begin
            r_state     <= ST_STEP;
            r_halted    <= 1'b0;
            r_step_seen <= 1'b1;
          end
        end
        ST_STEP: begin
          if (i_enable_debug) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_RUN;
          r_halted <= 1'b0;
        end
      endcase
      if ((r_state == ST_HALT) && !i_step) begin
        r_step_seen <= 1'b0;
      end
    end
  end

  // Payload/valid: frozen when not live, flush beats stall, otherwise load.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_q     <= RESET_VAL;
      r_valid <= RESET_VALID;
    end else if (w_live) begin
      if (bus.i_flush) begin
        r_q     <= BUBBLE_VAL;
        r_valid <= 1'b0;
      end else if (!bus.i_stall) begin
        r_q     <= bus.i_d;
        r_valid <= bus.i_valid_in;
      end
    end
  end

  // Saturating count of genuinely stalled cycles; clear wins over increment.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
    end else if (i_clr_cnt) begin
      r_stall_cnt <= '0;
    end else if (w_live && bus.i_stall && !bus.i_flush && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.o_q         = r_q;
  assign bus.o_valid_out = r_valid;
  assign o_halted        = r_halted;
  assign o_stall_cnt     = r_stall_cnt;

endmodule
